// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory read-port arbiter.
// Imported by imem_arbiter_if and imem_arbiter.
//   owner_e         : who owns the response currently held in the output register
//   STARVE_CNT_W    : width of the load-unit starvation counter
//   STARVE_MAX_DEF  : default number of lost conflicts before the load unit wins
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam int STARVE_CNT_W   = 4;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the load unit, the arbiter and the
// instruction memory read port.
//   slave  : arbiter side (takes requests and memory data, drives grants,
//            responses and the memory address)
//   master : requesters plus memory side (the opposite directions)
// Optional macro IMEM_ARB_MISALIGN_CHK_EN adds if_err_o / ls_err_o.
interface imem_arbiter_if #(
    parameter int IMEM_W = 14
);
    logic              if_req_i;
    logic [IMEM_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              ls_req_i;
    logic [IMEM_W-1:0] ls_addr_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic [IMEM_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    logic              if_err_o;
    logic              ls_err_o;
`endif

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, mem_rdata_i,
`ifdef IMEM_ARB_MISALIGN_CHK_EN
        output if_err_o, ls_err_o,
`endif
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, mem_addr_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_addr_i, mem_rdata_i,
`ifdef IMEM_ARB_MISALIGN_CHK_EN
        input  if_err_o, ls_err_o,
`endif
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, mem_addr_o
    );

endinterface

// File: rtl/imem_arbiter.sv
// Shares the single combinational instruction-memory read port between the
// fetch stage (fixed priority) and the load unit. A starvation counter lets
// the load unit win a conflict after STARVE_MAX consecutive losses. Grants
// are combinational; read data is registered and returned one cycle later.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : imem_arbiter_if.slave (requests, grants, responses, memory pins)
// Optional macro IMEM_ARB_MISALIGN_CHK_EN: flags responses whose granted
// address has addr[1:0] != 0 (err asserted with rvalid, rdata forced to 0).
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int IMEM_W     = 14,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    imem_arbiter_if.slave    bus
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [IMEM_W-1:0]       addr_q;
    logic [31:0]             rdata_q;
    owner_e                  owner_q;
    logic                    ls_win;
    logic                    if_gnt;
    logic                    ls_gnt;
    logic [IMEM_W-1:0]       mem_addr;

    // Load wins when alone, or when it has lost STARVE_MAX conflicts in a row.
    // Grants are masked during reset so nothing is accepted that would be lost.
    always_comb begin
        ls_win = bus.ls_req_i && (!bus.if_req_i || (starve_cnt == STARVE_LIM));
        if_gnt = rst_ni && bus.if_req_i && !ls_win;
        ls_gnt = rst_ni && bus.ls_req_i && ls_win;
        // Idle cycles replay the last granted address to avoid toggling the pins.
        if (if_gnt)      mem_addr = bus.if_addr_i;
        else if (ls_gnt) mem_addr = bus.ls_addr_i;
        else             mem_addr = addr_q;
    end

    assign bus.if_gnt_o   = if_gnt;
    assign bus.ls_gnt_o   = ls_gnt;
    assign bus.mem_addr_o = mem_addr;

    // Starvation counter: counts consecutive lost cycles of a pending load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (!bus.ls_req_i || ls_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    logic err_q;
    logic misalign;
    assign misalign = |mem_addr[1:0];
`endif

    // Response register: captures the memory word and its owner on each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            rdata_q <= '0;
            owner_q <= OWN_NONE;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (if_gnt || ls_gnt) begin
                addr_q  <= mem_addr;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
                rdata_q <= misalign ? 32'h0 : bus.mem_rdata_i;
                err_q   <= misalign;
`else
                rdata_q <= bus.mem_rdata_i;
`endif
            end
            if (if_gnt)      owner_q <= OWN_IF;
            else if (ls_gnt) owner_q <= OWN_LS;
            else             owner_q <= OWN_NONE;
        end
    end

    assign bus.if_rvalid_o = (owner_q == OWN_IF);
    assign bus.ls_rvalid_o = (owner_q == OWN_LS);
    assign bus.if_rdata_o  = (owner_q == OWN_IF) ? rdata_q : 32'h0;
    assign bus.ls_rdata_o  = (owner_q == OWN_LS) ? rdata_q : 32'h0;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign bus.if_err_o    = (owner_q == OWN_IF) && err_q;
    assign bus.ls_err_o    = (owner_q == OWN_LS) && err_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset values, single-requester reads,
// fetch/load conflicts with STARVE_MAX=4 and STARVE_MAX=1, back-to-back
// fetches, reset mid-access and misaligned load addresses.
module tb_imem_arbiter;

    localparam int IMEM_W = 14;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:4095];

    imem_arbiter_if #(.IMEM_W(IMEM_W)) bus ();
    imem_arbiter_if #(.IMEM_W(IMEM_W)) bus1 ();

    imem_arbiter #(.IMEM_W(IMEM_W), .STARVE_MAX(4)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    // Second instance sees the same requests; used for the STARVE_MAX=1 case.
    imem_arbiter #(.IMEM_W(IMEM_W), .STARVE_MAX(1)) dut1 (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus1)
    );

    assign bus.mem_rdata_i  = mem[bus.mem_addr_o[IMEM_W-1:2]];
    assign bus1.mem_rdata_i = mem[bus1.mem_addr_o[IMEM_W-1:2]];
    assign bus1.if_req_i    = bus.if_req_i;
    assign bus1.if_addr_i   = bus.if_addr_i;
    assign bus1.ls_req_i    = bus.ls_req_i;
    assign bus1.ls_addr_i   = bus.ls_addr_i;

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int  ecnt;
        logic exp_l;
        logic exp_l1;
        logic prev_l;

        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h020] = 32'h1234_5678;

        // Reset: grants forced low even with a pending request.
        rst_ni         = 1'b0;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 14'h040;
        bus.ls_req_i   = 1'b0;
        bus.ls_addr_i  = '0;
        #2;
        check("rst_if_gnt",    32'(bus.if_gnt_o),    32'h0);
        check("rst_ls_gnt",    32'(bus.ls_gnt_o),    32'h0);
        check("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
        check("rst_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h0);
        check("rst_if_rdata",  bus.if_rdata_o,       32'h0);
        check("rst_ls_rdata",  bus.ls_rdata_o,       32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr_o),  32'h0);
        check("rst_starve",    32'(dut.starve_cnt),  32'h0);
        bus.if_req_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;

        // Fetch only, first cycle out of reset.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 14'h040;
        #1;
        check("f_if_gnt",   32'(bus.if_gnt_o),   32'h1);
        check("f_ls_gnt",   32'(bus.ls_gnt_o),   32'h0);
        check("f_mem_addr", 32'(bus.mem_addr_o), 32'h040);
        tick();
        check("f_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        check("f_if_rdata",  bus.if_rdata_o,       32'hDEAD_BEEF);
        check("f_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h0);
        check("f_ls_rdata",  bus.ls_rdata_o,       32'h0);
        bus.if_req_i = 1'b0;
        #1;
        check("f_idle_gnt",  32'(bus.if_gnt_o),   32'h0);
        check("f_hold_addr", 32'(bus.mem_addr_o), 32'h040);
        tick();
        check("f_rvalid_1cyc", 32'(bus.if_rvalid_o), 32'h0);

        // Load only.
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 14'h080;
        #1;
        check("l_ls_gnt", 32'(bus.ls_gnt_o), 32'h1);
        check("l_if_gnt", 32'(bus.if_gnt_o), 32'h0);
        tick();
        check("l_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h1);
        check("l_ls_rdata",  bus.ls_rdata_o,       32'h1234_5678);
        check("l_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
        check("l_if_rdata",  bus.if_rdata_o,       32'h0);
        bus.ls_req_i = 1'b0;
        tick();

        // Continuous conflict: expect F,F,F,F,L,... (dut) and F,L,F,L,... (dut1).
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 14'h100;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 14'h200;
        ecnt = 0;
        for (int i = 0; i < 10; i++) begin
            exp_l  = (ecnt == 4);
            exp_l1 = (i % 2 == 1);
            #1;
            check($sformatf("c%0d_if_gnt", i),  32'(bus.if_gnt_o),   32'(!exp_l));
            check($sformatf("c%0d_ls_gnt", i),  32'(bus.ls_gnt_o),   32'(exp_l));
            check($sformatf("c%0d_starve", i),  32'(dut.starve_cnt), 32'(ecnt));
            check($sformatf("c%0d_s1_ls", i),   32'(bus1.ls_gnt_o),  32'(exp_l1));
            check($sformatf("c%0d_s1_if", i),   32'(bus1.if_gnt_o),  32'(!exp_l1));
            prev_l = exp_l;
            tick();
            check($sformatf("c%0d_if_rvalid", i), 32'(bus.if_rvalid_o), 32'(!prev_l));
            check($sformatf("c%0d_ls_rvalid", i), 32'(bus.ls_rvalid_o), 32'(prev_l));
            check($sformatf("c%0d_rdata", i), prev_l ? bus.ls_rdata_o : bus.if_rdata_o,
                  prev_l ? (32'hA500_0000 | 32'h080) : (32'hA500_0000 | 32'h040));
            ecnt = exp_l ? 0 : ecnt + 1;
        end
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        tick();

        // Back-to-back fetches: 8 grants, 8 consecutive responses in order.
        for (int i = 0; i < 8; i++) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 14'(i * 4);
            #1;
            check($sformatf("b%0d_gnt", i), 32'(bus.if_gnt_o), 32'h1);
            tick();
            check($sformatf("b%0d_rvalid", i), 32'(bus.if_rvalid_o), 32'h1);
            check($sformatf("b%0d_rdata", i),  bus.if_rdata_o, 32'hA500_0000 | 32'(i));
        end
        bus.if_req_i = 1'b0;
        tick();
        check("b_end_rvalid", 32'(bus.if_rvalid_o), 32'h0);

        // Reset mid-access: build up starve_cnt, grant, then pulse reset.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 14'h040;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 14'h080;
        tick();
        check("r_starve_pre", 32'(dut.starve_cnt), 32'h1);
        #1;
        check("r_gnt_pre", 32'(bus.if_gnt_o), 32'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("r_gnt_forced", 32'(bus.if_gnt_o), 32'h0);
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        #1;
        rst_ni = 1'b1;
        tick();
        check("r_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
        check("r_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h0);
        check("r_if_rdata",  bus.if_rdata_o,       32'h0);
        check("r_mem_addr",  32'(bus.mem_addr_o),  32'h0);
        check("r_starve",    32'(dut.starve_cnt),  32'h0);

        // Misaligned load address.
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 14'h082;
        #1;
        check("m_ls_gnt", 32'(bus.ls_gnt_o), 32'h1);
        tick();
        check("m_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h1);
`ifdef IMEM_ARB_MISALIGN_CHK_EN
        check("m_ls_err",   32'(bus.ls_err_o), 32'h1);
        check("m_if_err",   32'(bus.if_err_o), 32'h0);
        check("m_ls_rdata", bus.ls_rdata_o,    32'h0);
        bus.ls_addr_i = 14'h080;
        tick();
        check("m_al_err",   32'(bus.ls_err_o), 32'h0);
        check("m_al_rdata", bus.ls_rdata_o,    32'h1234_5678);
`else
        check("m_ls_rdata", bus.ls_rdata_o, 32'h1234_5678);
`endif
        bus.ls_req_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
